// File: rtl/ex_div.sv
// 32-bit restoring divider for the EX stage: signed (DIV) or unsigned (DIVU),
// one quotient bit per clock, result held until the requester drops start_i.
module ex_div (
    input  logic        clk,
    input  logic        rst,
    input  logic        signed_div_i,
    input  logic [31:0] opdata1_i,
    input  logic [31:0] opdata2_i,
    input  logic        start_i,
    input  logic        annul_i,
    output logic [63:0] result_o,
    output logic        ready_o,
    output logic        stallreq_o
);

    // state  | meaning
    // IDLE   | waiting for a division request
    // BYZERO | divisor was zero, result forced to 0 on the next edge
    // ON     | 32 restoring iterations, then sign correction
    // END    | result valid, held until start_i drops or annul_i
    typedef enum logic [1:0] {IDLE, BYZERO, ON, END} state_t;

    state_t      state;
    logic [5:0]  cnt;
    logic [64:0] work;
    logic [31:0] divisor_mag;
    logic        sgn_mode;
    logic        neg_dividend;
    logic        neg_divisor;

    logic [31:0] dividend_in_mag;
    logic [31:0] divisor_in_mag;
    logic [32:0] diff;
    logic [31:0] quot_raw;
    logic [31:0] rem_raw;
    logic [31:0] quot_fix;
    logic [31:0] rem_fix;

    assign dividend_in_mag = (signed_div_i && opdata1_i[31]) ? (~opdata1_i + 32'd1) : opdata1_i;
    assign divisor_in_mag  = (signed_div_i && opdata2_i[31]) ? (~opdata2_i + 32'd1) : opdata2_i;

    // Top bit of diff set means the partial remainder is below the divisor.
    assign diff     = {1'b0, work[63:32]} - {1'b0, divisor_mag};
    assign quot_raw = work[31:0];
    assign rem_raw  = work[64:33];
    assign quot_fix = (sgn_mode && (neg_dividend ^ neg_divisor)) ? (~quot_raw + 32'd1) : quot_raw;
    assign rem_fix  = (sgn_mode && neg_dividend) ? (~rem_raw + 32'd1) : rem_raw;

    assign stallreq_o = start_i & ~ready_o & ~annul_i & ~rst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= 6'd0;
            work         <= 65'd0;
            divisor_mag  <= 32'd0;
            sgn_mode     <= 1'b0;
            neg_dividend <= 1'b0;
            neg_divisor  <= 1'b0;
            result_o     <= 64'd0;
            ready_o      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    ready_o  <= 1'b0;
                    result_o <= 64'd0;
                    if (start_i && !annul_i) begin
                        if (opdata2_i == 32'd0) begin
                            state <= BYZERO;
                        end else begin
                            state        <= ON;
                            cnt          <= 6'd0;
                            work         <= {32'd0, dividend_in_mag, 1'b0};
                            divisor_mag  <= divisor_in_mag;
                            sgn_mode     <= signed_div_i;
                            neg_dividend <= opdata1_i[31];
                            neg_divisor  <= opdata2_i[31];
                        end
                    end
                end
                BYZERO: begin
                    if (annul_i) begin
                        state <= IDLE;
                    end else begin
                        state    <= END;
                        ready_o  <= 1'b1;
                        result_o <= 64'd0;
                    end
                end
                ON: begin
                    if (annul_i) begin
                        state <= IDLE;
                    end else if (cnt == 6'd32) begin
                        state    <= END;
                        ready_o  <= 1'b1;
                        result_o <= {rem_fix, quot_fix};
                    end else begin
                        work <= diff[32] ? {work[63:0], 1'b0}
                                         : {diff[31:0], work[31:0], 1'b1};
                        cnt  <= cnt + 6'd1;
                    end
                end
                END: begin
                    if (annul_i || !start_i) begin
                        state    <= IDLE;
                        ready_o  <= 1'b0;
                        result_o <= 64'd0;
                    end
                end
                default: begin
                    state    <= IDLE;
                    ready_o  <= 1'b0;
                    result_o <= 64'd0;
                end
            endcase
        end
    end

endmodule
